rv64i_mem_arbiter: RTL
======================

Name: rv64i_mem_arbiter

Overview:
- Shares the single unified 64-bit instruction/data memory between two requesters: the IF stage (fetch, read-only) and the MEM stage (load/store).
- Accepts at most one access at a time and routes the response back to the requester that owns it.
- Priority: data over fetch, with a starvation guard for fetch, a response watchdog and a quiesce (halt) handshake.
- Sits between the pipeline stages and the memory model; the pipeline stalls IF/MEM while the corresponding grant/rvalid is pending.

Parameters:
- ADDR_W, 64, byte address width of all address ports.
- DATA_W, 64, data width.
- STARVE_MAX, 4, consecutive lost arbitrations after which IF wins over MEM; legal range 1..15.
- TIMEOUT, 16, WAIT-state cycles without mem_rvalid before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch accepted
- if_rvalid  out  1  one-cycle pulse: fetch data valid
- if_rdata  out  DATA_W  fetch data, valid with if_rvalid
- dm_req  in  1  data request; held with payload stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse: data access accepted
- dm_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged
- dm_rdata  out  DATA_W  load data; 0 for store acks
- mem_req  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  ADDR_W  memory address, valid with mem_req
- mem_wdata  out  DATA_W  memory write data, valid with mem_req
- mem_rvalid  in  1  memory completion; also used as the write ack
- mem_rdata  in  DATA_W  memory read data
- halt_req  in  1  request to quiesce the memory port
- halt_ack  out  1  high while halted: halt_req=1 and no access outstanding
- bus_err  out  1  one-cycle pulse on watchdog timeout or spurious mem_rvalid

Behaviour:
- Reset values (all asserted during reset): every output 0; FSM state IDLE; owner=NONE; starve_cnt=0; wd_cnt=0.
- FSM has two states, IDLE and WAIT.
- IDLE, arbitration (evaluated only when halt_req=0):
  - dm_req=1 and (if_req=0 or starve_cnt<STARVE_MAX) -> DM wins.
  - else if_req=1 -> IF wins.
  - On a win in cycle N: the winner's gnt=1 and mem_req=1 combinationally in cycle N.
  - mem_we/addr/wdata are muxed from the winner. IF is always a read, with mem_wdata=0.
  - At the edge ending cycle N: owner latched, state=WAIT, wd_cnt=0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when IF requests but DM wins.
  - Clears on if_gnt, or on any IDLE cycle with if_req=0.
- WAIT:
  - mem_req=0; no grants.
  - On mem_rvalid=1: the owner's rvalid=1 and rdata=mem_rdata in the same cycle (dm_rdata=0 if the latched op was a store). Next state IDLE.
  - Minimum access cost is therefore 3 cycles from req to next grant (grant, response, re-arbitrate); there is no back-to-back grant in the response cycle.
- Watchdog:
  - wd_cnt increments each WAIT cycle without mem_rvalid.
  - When it reaches TIMEOUT-1 with no mem_rvalid: bus_err=1, the owner's rvalid=1 with rdata=0, state=IDLE.
- mem_rvalid=1 in IDLE is ignored for routing (no rvalid on any port) and pulses bus_err.
- Halt:
  - halt_req=1 blocks new grants in IDLE; an outstanding WAIT access still completes.
  - halt_ack = (state==IDLE) & halt_req, registered, so it rises the cycle after IDLE is reached.
  - Deasserting halt_req drops halt_ack next cycle; arbitration resumes that same cycle.
- Simultaneous events:
  - if_req and dm_req in the same IDLE cycle resolve per the priority rule; exactly one gnt per cycle.
  - The loser keeps its req asserted and gets no gnt.
- Requests deasserted before grant are legal; nothing is latched.
- Reset mid-WAIT drops the outstanding access with no rvalid; the memory model is reset by the same signal.
- gnt and rvalid never assert for both ports in one cycle. mem_req never asserts in WAIT.

Decomposition:
- Shared package rv64i_pkg holds:
  - Owner encoding: NONE=2'b00, IF=2'b01, DM=2'b10.
  - FSM state encoding: IDLE, WAIT.
  - XLEN=64.
- One sub-module is natural, rv64i_arb_prio: combinational priority pick plus the starve_cnt register, with outputs win_if/win_dm.
- The FSM, watchdog and datapath muxes stay in the top module.

Test Plan:
- if_req=1 alone, if_addr=0x40, memory returns 0x0000_0013 one cycle later -> if_gnt in cycle 0, mem_req/mem_addr=0x40 in cycle 0, if_rvalid with if_rdata=0x13 in cycle 1, bus_err=0.
- if_req and dm_req held continuously (dm loads), STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM,...; starve_cnt returns to 0 after if_gnt.
- Store dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF -> mem_we=1 with that address/data in the grant cycle; dm_rvalid=1 with dm_rdata=0 on the ack.
- Grant a load and withhold mem_rvalid, TIMEOUT=16 -> bus_err and dm_rvalid pulse with dm_rdata=0 in the 16th WAIT cycle; IDLE next cycle; a later spurious mem_rvalid pulses bus_err only.
- Assert halt_req during WAIT -> the access completes normally, halt_ack=1 from the next cycle on, no gnt while halt_req=1; release halt_req -> pending if_req granted that same cycle.
- Assert reset mid-WAIT -> all outputs 0 immediately; after release, a fresh request is granted normally with no stray rvalid.

Source files
------------

// File: rtl/rv64i_pkg.sv
// Shared encodings for the rv64i memory arbiter slice.
// Owner and FSM state enums plus the machine word width.
package rv64i_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DM   = 2'b10
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/rv64i_mem_arbiter_if.sv
// Pipeline/memory-side bundle of the unified memory arbiter.
// slave = arbiter view; master = pipeline stages plus memory model.
interface rv64i_mem_arbiter_if
  import rv64i_pkg::*;
#(
  parameter int ADDR_W = XLEN,
  parameter int DATA_W = XLEN
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              halt_req;
  logic              halt_ack;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata,
    input  halt_req,
    output halt_ack, bus_err
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata,
    output halt_req,
    input  halt_ack, bus_err
  );
endinterface

// File: rtl/rv64i_arb_prio.sv
// Data-over-fetch priority pick with a saturating starvation counter for fetch.
// Pick is combinational; only the counter is registered.
module rv64i_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic win_if,
  output logic win_dm
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  assign win_dm = arb_en & dm_req & (~if_req | (starve_cnt < SMAX));
  assign win_if = arb_en & if_req & ~win_dm;

  // Counts lost arbitrations by a waiting fetch; any idle gap in fetch clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (win_if || (idle && !if_req)) begin
      starve_cnt <= '0;
    end else if (win_dm && if_req && (starve_cnt < SMAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/rv64i_mem_arbiter.sv
// Shares one unified memory between fetch and load/store, one access in flight,
// with response watchdog, spurious-response detection and a halt handshake.
module rv64i_mem_arbiter
  import rv64i_pkg::*;
#(
  parameter int ADDR_W     = XLEN,
  parameter int DATA_W     = XLEN,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  rv64i_mem_arbiter_if.slave  bus
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e     state, state_nx;
  owner_e     owner, owner_nx;
  logic       op_we, op_we_nx;
  logic [7:0] wd_cnt, wd_cnt_nx;
  logic       halt_ack_q;

  logic              win_if, win_dm;
  logic              if_gnt_c, dm_gnt_c, if_rvalid_c, dm_rvalid_c, bus_err_c;
  logic              mem_req_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c, rdata_c;

  wire idle   = (state == ST_IDLE);
  wire arb_en = idle & ~bus.halt_req;

  rv64i_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .reset  (reset),
    .idle   (idle),
    .arb_en (arb_en),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .win_if (win_if),
    .win_dm (win_dm)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      op_we      <= 1'b0;
      wd_cnt     <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      op_we      <= op_we_nx;
      wd_cnt     <= wd_cnt_nx;
      halt_ack_q <= idle & bus.halt_req;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    op_we_nx    = op_we;
    wd_cnt_nx   = wd_cnt;
    if_gnt_c    = 1'b0;
    dm_gnt_c    = 1'b0;
    if_rvalid_c = 1'b0;
    dm_rvalid_c = 1'b0;
    bus_err_c   = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    rdata_c     = '0;
    case (state)
      ST_IDLE: begin
        // Nothing is outstanding, so any completion here is spurious.
        bus_err_c = bus.mem_rvalid;
        if (win_dm) begin
          dm_gnt_c    = 1'b1;
          mem_req_c   = 1'b1;
          mem_we_c    = bus.dm_we;
          mem_addr_c  = bus.dm_addr;
          mem_wdata_c = bus.dm_wdata;
          owner_nx    = OWN_DM;
          op_we_nx    = bus.dm_we;
          state_nx    = ST_WAIT;
          wd_cnt_nx   = '0;
        end else if (win_if) begin
          if_gnt_c    = 1'b1;
          mem_req_c   = 1'b1;
          mem_addr_c  = bus.if_addr;
          owner_nx    = OWN_IF;
          op_we_nx    = 1'b0;
          state_nx    = ST_WAIT;
          wd_cnt_nx   = '0;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid || wd_cnt == WD_LAST) begin
          if_rvalid_c = (owner == OWN_IF);
          dm_rvalid_c = (owner == OWN_DM);
          bus_err_c   = ~bus.mem_rvalid;
          // Store acks and watchdog aborts return zero data.
          rdata_c     = (bus.mem_rvalid && !op_we) ? bus.mem_rdata : '0;
          owner_nx    = OWN_NONE;
          state_nx    = ST_IDLE;
        end else begin
          wd_cnt_nx = wd_cnt + 8'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign bus.if_gnt    = if_gnt_c & ~reset;
  assign bus.dm_gnt    = dm_gnt_c & ~reset;
  assign bus.if_rvalid = if_rvalid_c & ~reset;
  assign bus.dm_rvalid = dm_rvalid_c & ~reset;
  assign bus.if_rdata  = (if_rvalid_c && !reset) ? rdata_c : '0;
  assign bus.dm_rdata  = (dm_rvalid_c && !reset) ? rdata_c : '0;
  assign bus.mem_req   = mem_req_c & ~reset;
  assign bus.mem_we    = mem_we_c & ~reset;
  assign bus.mem_addr  = reset ? '0 : mem_addr_c;
  assign bus.mem_wdata = reset ? '0 : mem_wdata_c;
  assign bus.bus_err   = bus_err_c & ~reset;
  assign bus.halt_ack  = halt_ack_q;

endmodule
